// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment read-back path.
// SEG7_DP_EN widens the compared pattern to include the decimal point.
package seg7_pkg;

`ifdef SEG7_DP_EN
   localparam int SEG7_PAT_W = 8;
`else
   localparam int SEG7_PAT_W = 7;
`endif

   // Active-high glyphs, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG7_BLANK   = 7'b0000000;
   localparam logic [6:0] SEG7_GLYPH_0 = 7'b1111110;
   localparam logic [6:0] SEG7_GLYPH_1 = 7'b0110000;
   localparam logic [6:0] SEG7_GLYPH_2 = 7'b1101101;
   localparam logic [6:0] SEG7_GLYPH_3 = 7'b1111001;
   localparam logic [6:0] SEG7_GLYPH_4 = 7'b0110011;
   localparam logic [6:0] SEG7_GLYPH_5 = 7'b1011011;
   localparam logic [6:0] SEG7_GLYPH_6 = 7'b1011111;
   localparam logic [6:0] SEG7_GLYPH_7 = 7'b1110000;
   localparam logic [6:0] SEG7_GLYPH_8 = 7'b1111111;
   localparam logic [6:0] SEG7_GLYPH_9 = 7'b1111011;
   localparam logic [6:0] SEG7_GLYPH_A = 7'b1110111;
   localparam logic [6:0] SEG7_GLYPH_B = 7'b0011111;
   localparam logic [6:0] SEG7_GLYPH_C = 7'b1001110;
   localparam logic [6:0] SEG7_GLYPH_D = 7'b0111101;
   localparam logic [6:0] SEG7_GLYPH_E = 7'b1001111;
   localparam logic [6:0] SEG7_GLYPH_F = 7'b1000111;

   typedef enum logic {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment table.
// Illegal patterns report err with code 0; the all-off pattern reports blank.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] code_o,
   output logic       err_o,
   output logic       blank_o
);

   always_comb begin
      code_o  = 4'h0;
      err_o   = 1'b0;
      blank_o = 1'b0;
      case (pattern_i)
         SEG7_GLYPH_0: code_o = 4'h0;
         SEG7_GLYPH_1: code_o = 4'h1;
         SEG7_GLYPH_2: code_o = 4'h2;
         SEG7_GLYPH_3: code_o = 4'h3;
         SEG7_GLYPH_4: code_o = 4'h4;
         SEG7_GLYPH_5: code_o = 4'h5;
         SEG7_GLYPH_6: code_o = 4'h6;
         SEG7_GLYPH_7: code_o = 4'h7;
         SEG7_GLYPH_8: code_o = 4'h8;
         SEG7_GLYPH_9: code_o = 4'h9;
         SEG7_GLYPH_A: code_o = 4'hA;
         SEG7_GLYPH_B: code_o = 4'hB;
         SEG7_GLYPH_C: code_o = 4'hC;
         SEG7_GLYPH_D: code_o = 4'hD;
         SEG7_GLYPH_E: code_o = 4'hE;
         SEG7_GLYPH_F: code_o = 4'hF;
         SEG7_BLANK:   blank_o = 1'b1;
         default:      err_o   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_hex_reader.sv
// Reads a debounced 7-segment pattern back to a hex nibble on a valid/ready port.
// Optional decimal point tracking is enabled with SEG7_DP_EN.
module seg7_hex_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_c,
   input  logic       i_d,
   input  logic       i_e,
   input  logic       i_f,
   input  logic       i_g,
`ifdef SEG7_DP_EN
   input  logic       i_dp,
   output logic       o_dp,
`endif
   input  logic       i_ready,
   output logic [3:0] o_code,
   output logic       o_err,
   output logic       o_valid,
   output logic       o_overrun,
   output logic       o_dbg_state
);
   import seg7_pkg::*;

   localparam int         W       = SEG7_PAT_W;
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   logic [W-1:0] pins, pat_in;
   logic [W-1:0] s1_q, s2_q, p_q, last_q, last_d;
   logic [7:0]   cnt_q, cnt_d;
   seg7_state_e  state_q, state_d;
   logic [3:0]   code_q, code_d, dec_code;
   logic         err_q, err_d, valid_q, valid_d, ovr_q, ovr_d;
   logic         dec_err, dec_blank, same, accept, report;

`ifdef SEG7_DP_EN
   logic dp_q, dp_d;
   assign pins = {i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dp};
   assign o_dp = dp_q;
`else
   assign pins = {i_a, i_b, i_c, i_d, i_e, i_f, i_g};
`endif

   assign pat_in = (ACTIVE_LOW != 0) ? ~pins : pins;
   assign same   = (s2_q == p_q);

   // Blank/glyph decisions look only at a..g, so a lone dp still counts as blank
   seg7_pattern_decode u_dec (
      .pattern_i (s2_q[W-1 -: 7]),
      .code_o    (dec_code),
      .err_o     (dec_err),
      .blank_o   (dec_blank)
   );

   always_comb begin
      cnt_d = 8'd0;
      if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         TRACK: if (same && cnt_q == CNT_MAX) begin
            accept  = 1'b1;
            state_d = HOLD;
         end
         HOLD:    if (!same) state_d = TRACK;
         default: state_d = TRACK;
      endcase
   end

   // A stable pattern equal to the last accepted one (e.g. after a short glitch) is not re-reported
   assign report = accept && (s2_q != last_q) && !dec_blank;
   assign last_d = accept ? s2_q : last_q;

   // Handshake: a word transfers on any edge where o_valid && i_ready; new data may
   // replace un-taken data (flagged by o_overrun) and valid never drops without a transfer.
   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      err_d   = err_q;
      ovr_d   = 1'b0;
`ifdef SEG7_DP_EN
      dp_d    = dp_q;
`endif
      if (report) begin
         valid_d = 1'b1;
         code_d  = dec_code;
         err_d   = dec_err;
         ovr_d   = valid_q && !i_ready;
`ifdef SEG7_DP_EN
         dp_d    = s2_q[0];
`endif
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         p_q     <= '0;
         last_q  <= '0;
         cnt_q   <= 8'd0;
         state_q <= TRACK;
         code_q  <= 4'h0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SEG7_DP_EN
         dp_q    <= 1'b0;
`endif
      end else begin
         s1_q    <= pat_in;
         s2_q    <= s1_q;
         p_q     <= s2_q;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         code_q  <= code_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SEG7_DP_EN
         dp_q    <= dp_d;
`endif
      end
   end

   assign o_code      = code_q;
   assign o_err       = err_q;
   assign o_valid     = valid_q;
   assign o_overrun   = ovr_q;
   assign o_dbg_state = logic'(state_q);

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Directed and randomized bench for seg7_hex_reader against a run-length reference model.
// Builds with or without SEG7_DP_EN.
module tb_seg7_hex_reader;
   localparam int SC = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       ready = 1'b0;
   logic [6:0] pins  = 7'h00;
   logic [3:0] o_code;
   logic       o_err, o_valid, o_ovr, o_dbg;

   logic [6:0] al_pins  = 7'h7f;
   logic       al_ready = 1'b0;
   logic [3:0] al_code;
   logic       al_err, al_valid, al_ovr, al_dbg;
`ifdef SEG7_DP_EN
   logic       dp_out, al_dp_out;
   logic       al_dp_in = 1'b1;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt  = 0;
   int ocnt  = 0;
   int lat;

   // Reference model state
   logic [6:0] hist[$] = '{7'h00, 7'h00, 7'h00};
   logic [6:0] last_m  = 7'h00;
   logic       m_valid = 1'b0;
   logic [3:0] m_code  = 4'h0;
   logic       m_err   = 1'b0;
   logic       m_ovr   = 1'b0;

   logic [6:0] glyph[16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   always #5 clk = ~clk;

   seg7_hex_reader #(.STABLE_CYCLES(SC), .ACTIVE_LOW(0)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a(pins[6]), .i_b(pins[5]), .i_c(pins[4]), .i_d(pins[3]),
      .i_e(pins[2]), .i_f(pins[1]), .i_g(pins[0]),
`ifdef SEG7_DP_EN
      .i_dp(1'b0), .o_dp(dp_out),
`endif
      .i_ready(ready), .o_code(o_code), .o_err(o_err), .o_valid(o_valid),
      .o_overrun(o_ovr), .o_dbg_state(o_dbg)
   );

   seg7_hex_reader #(.STABLE_CYCLES(1), .ACTIVE_LOW(1)) dut_al (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a(al_pins[6]), .i_b(al_pins[5]), .i_c(al_pins[4]), .i_d(al_pins[3]),
      .i_e(al_pins[2]), .i_f(al_pins[1]), .i_g(al_pins[0]),
`ifdef SEG7_DP_EN
      .i_dp(al_dp_in), .o_dp(al_dp_out),
`endif
      .i_ready(al_ready), .o_code(al_code), .o_err(al_err), .o_valid(al_valid),
      .o_overrun(al_ovr), .o_dbg_state(al_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Table lookup of a glyph; err for unknown non-blank patterns
   task automatic ref_decode(input logic [6:0] p, output logic [3:0] c, output logic e);
      c = 4'h0;
      e = (p != 7'h00);
      for (int k = 0; k < 16; k++)
         if (glyph[k] == p) begin
            c = 4'(k);
            e = 1'b0;
         end
   endtask

   // One clock: advance the model on the inputs seen at the edge, then compare at #1
   task automatic tick();
      int         top, run;
      logic [6:0] s;
      logic [3:0] c;
      logic       e, acc;
      @(posedge clk);
      if (!rst_n) begin
         hist    = '{7'h00, 7'h00, 7'h00};
         last_m  = 7'h00;
         m_valid = 1'b0;
         m_code  = 4'h0;
         m_err   = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         hist.push_back(pins);
         if (hist.size() > 16) void'(hist.pop_front());
         // The synchronized value the DUT judges lags the pins by two edges
         top = hist.size() - 3;
         s   = hist[top];
         run = 0;
         for (int i = top; i >= 0; i--) begin
            if (hist[i] != s) break;
            run++;
         end
         acc   = (run == SC + 1);
         m_ovr = 1'b0;
         if (acc && s != last_m && s != 7'h00) begin
            ref_decode(s, c, e);
            m_ovr   = m_valid && !ready;
            m_valid = 1'b1;
            m_code  = c;
            m_err   = e;
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
         if (acc) last_m = s;
      end
      #1;
      chk("valid", o_valid, m_valid);
      chk("code", o_code, m_code);
      chk("err", o_err, m_err);
      chk("overrun", o_ovr, m_ovr);
      if (o_valid) vcnt++;
      if (o_ovr) ocnt++;
   endtask

   task automatic run_until_valid(input int limit, output int l);
      l = -1;
      for (int k = 1; k <= limit; k++) begin
         tick();
         if (o_valid) begin
            l = k - 1;
            break;
         end
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_code", o_code, 4'h0);
      chk("rst_state", o_dbg, 1'b0);
      rst_n = 1'b1;
      repeat (6) tick();
      chk("blank_silent", vcnt, 0);

      // Sweep all glyphs separated by blank
      ready = 1'b1;
      for (int g = 0; g < 16; g++) begin
         vcnt = 0;
         pins = glyph[g];
         run_until_valid(12, lat);
         chk("sweep_lat", lat, 6);
         chk("sweep_code", o_code, g);
         chk("sweep_err", o_err, 1'b0);
         repeat (4) tick();
         pins = 7'h00;
         repeat (4) tick();
         chk("sweep_once", vcnt, 1);
      end

      // Short glitch on segment g
      vcnt = 0;
      pins = glyph[3];
      repeat (12) tick();
      pins = glyph[3] ^ 7'b0000001;
      repeat (2) tick();
      pins = glyph[3];
      repeat (12) tick();
      chk("glitch_reports", vcnt, 1);
      chk("glitch_code", o_code, 4'h3);

      // Illegal pattern, then blank
      ready = 1'b0;
      pins  = 7'b1010101;
      repeat (10) tick();
      chk("illegal_valid", o_valid, 1'b1);
      chk("illegal_err", o_err, 1'b1);
      chk("illegal_code", o_code, 4'h0);
      ready = 1'b1;
      tick();
      vcnt = 0;
      pins = 7'h00;
      repeat (10) tick();
      chk("illegal_blank", vcnt, 0);

      // Overrun
      ready = 1'b0;
      ocnt  = 0;
      pins  = glyph[1];
      repeat (10) tick();
      pins = glyph[2];
      repeat (10) tick();
      chk("ovr_pulses", ocnt, 1);
      chk("ovr_code", o_code, 4'h2);
      chk("ovr_held", o_valid, 1'b1);
      ready = 1'b1;
      tick();
      chk("ovr_drop", o_valid, 1'b0);

      // Reset mid-handshake with a count in progress
      ready = 1'b0;
      pins  = glyph[4];
      repeat (10) tick();
      pins = glyph[5];
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      chk("mrst_valid", o_valid, 1'b0);
      chk("mrst_code", o_code, 4'h0);
      chk("mrst_ovr", o_ovr, 1'b0);
      chk("mrst_state", o_dbg, 1'b0);
      rst_n = 1'b1;
      run_until_valid(12, lat);
      chk("mrst_lat", lat, 6);
      chk("mrst_code5", o_code, 4'h5);

      // Randomized patterns with random back-pressure
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0:       pins = 7'h00;
            3:       pins = 7'($urandom);
            default: pins = glyph[$urandom_range(0, 15)];
         endcase
         repeat ($urandom_range(1, 9)) begin
            ready = 1'($urandom_range(0, 1));
            tick();
         end
      end

      // Active-low pins, all driven low
      al_pins = 7'h00;
`ifdef SEG7_DP_EN
      al_dp_in = 1'b0;
`endif
      repeat (6) tick();
      chk("al_valid", al_valid, 1'b1);
      chk("al_code", al_code, 4'h8);
      chk("al_err", al_err, 1'b0);
`ifdef SEG7_DP_EN
      chk("al_dp", al_dp_out, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_hex_reader.md
# seg7_hex_reader

Reads a 7-segment drive pattern (a–g) back into a 4-bit hex code: the inverse of the hex-to-7-segment decoder. It synchronizes the segment lines, waits until the pattern has been stable for a programmable number of cycles, decodes it and presents the nibble on a valid/ready output. It sits on the loopback/monitor path of the display datapath, so self-checks and captured external displays can be compared against the binary adder result.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before acceptance; legal range is 1..255.
- ACTIVE_LOW, 0: 1 = segment inputs are active-low; they are inverted before the first synchronizer flop.
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  synchronous, active-low reset
- i_a … i_g  in  1 each  segment lines; pattern order is {a,b,c,d,e,f,g}, with a as the MSB
- o_code  out  4  decoded hex value, held while o_valid is asserted
- o_err  out  1  pattern is not one of the 16 legal glyphs; o_code = 0 when set
- o_valid  out  1  o_code/o_err are valid
- i_ready  in  1  consumer accepts the data; transfer occurs when o_valid && i_ready
- o_overrun  out  1  one-cycle pulse when unconsumed data is overwritten

## Operation
- Two-flop synchronizer s1→s2 on the (polarity-corrected) pattern. A register p holds the previous s2 value.
- Stability counter cnt:
  - cleared when s2 != p;
  - otherwise increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - TRACK: when s2 == p and cnt == STABLE_CYCLES-1, accept the pattern and go to HOLD.
  - HOLD: stay while s2 == p. Any change in s2 goes to TRACK with cnt = 0.
  - Each stable pattern is reported once; the same glyph is reported again only after an intervening change.
- Active-high glyphs for {a..g}:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- On accept:
  - A legal glyph loads o_code and sets o_err = 0.
  - Blank (0000000) is accepted silently: the FSM enters HOLD and no o_valid is raised.
  - Any other pattern loads o_code = 0 and sets o_err = 1.
- Output handshake:
  - o_valid is set on accept and cleared on the edge after o_valid && i_ready.
  - Accept while o_valid && !i_ready: the new data overwrites the old, o_valid stays 1 and o_overrun pulses.
  - Accept in the same cycle as a transfer: the new data loads, o_valid stays 1 and there is no overrun.

## Timing
- Reset (i_rst_n low at an edge):
  - s1, s2, p, cnt = 0; FSM = TRACK.
  - o_code = 0, o_err = 0, o_valid = 0, o_overrun = 0.
  - Because blank is silent, a blank pattern after reset never produces o_valid.
- Latency: a new pattern first captured in s1 at edge N gives o_valid = 1 after edge N+STABLE_CYCLES+2. With STABLE_CYCLES=1 that is edge N+3.
- A glitch shorter than STABLE_CYCLES cycles at s2 restarts the count and produces no output.
- Reset mid-handshake drops pending data. There is no overrun pulse on reset.
- All outputs are registered, and there is no combinational path from i_ready to any output.

## Configuration
- SEG7_DP_EN defined:
  - Adds port i_dp (in, 1) and port o_dp (out, 1).
  - The decimal point becomes bit 0 of an 8-bit compared/synchronized pattern; a dp-only change restarts stability.
  - o_dp is latched with o_code.
  - The blank check and the glyph match use only a–g, so dp alone is still treated as blank.
- SEG7_DP_EN undefined: there is no dp logic and no dp ports, and the pattern is 7 bits.

## Structure
- Package seg7_pkg holds:
  - the glyph constants SEG7_GLYPH_0 … SEG7_GLYPH_F and SEG7_BLANK;
  - the FSM state type (TRACK, HOLD);
  - the pattern-width constant, which depends on SEG7_DP_EN.
- One sub-module, seg7_pattern_decode: combinational pattern[6:0] → {code[3:0], err, blank}. Everything else lives at the top level.

## Test plan
All scenarios use STABLE_CYCLES=4 and ACTIVE_LOW=0 unless stated otherwise.
- Sweep: drive each of the 16 glyphs for 10 cycles, separated by blank, with i_ready=1. Expect code 0..F in order, o_err=0, each o_valid exactly 1 cycle, and the first o_valid 6 edges after the pattern change.
- Glitch: hold 1111001, toggle segment g for 2 cycles, restore, with i_ready=1. Expect exactly one report (code 3), no report for the glitch pattern, and no re-report after the restore.
- Illegal: drive 1010101 stably. Expect o_valid=1, o_err=1, o_code=0. Drive blank after it: no o_valid.
- Overrun: i_ready=0, then 0110000 stable followed by 1101101 stable. Expect o_overrun to pulse once, o_code=2 held, and o_valid to drop one edge after i_ready=1.
- Reset: assert i_rst_n=0 for 1 cycle while o_valid=1 and a count is in progress. Expect all outputs 0 after the edge and the next valid report a full 6 edges after release.
- Polarity and dp: with ACTIVE_LOW=1 and SEG7_DP_EN, drive pins 00000000 (all segments plus dp lit). Expect code 8 and o_dp=1.
